// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_pkg: shared state type and one-hot helper for the FIFO write arbiter
package fifo_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic logic [31:0] idx_to_onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/data bundle plus the FIFO write-port side
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_in;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_w_data;
    logic                          busy;

    modport master (
        output req, wr_data_in, fifo_full,
        input  grant, ack, fifo_wr, fifo_w_data, busy
    );

    modport slave (
        input  req, wr_data_in, fifo_full,
        output grant, ack, fifo_wr, fifo_w_data, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority encoder, first set req at or after start wins
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    // Walk from the farthest offset down so the nearest set bit overwrites last
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(start) + i) % NUM_REQ])
                idx = IW'((int'(start) + i) % NUM_REQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic           clk,
    input logic           reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t        state, state_n;
    logic [IW-1:0]     owner, owner_n;
    logic [IW-1:0]     last_owner, last_owner_n;
    logic [CW-1:0]     burst_cnt, burst_cnt_n;
    logic [IW-1:0]     start;
    logic [IW-1:0]     pick;
    logic              pick_valid;
    logic              in_burst;
    logic              wr;
    logic [NUM_REQ-1:0] owner_oh;

    assign start    = last_owner == IW'(NUM_REQ - 1) ? '0 : IW'(last_owner + 1'b1);
    assign owner_oh = NUM_REQ'(idx_to_onehot(32'(owner)));

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req),
        .start (start),
        .valid (pick_valid),
        .idx   (pick)
    );

    // State register; reset aborts any burst and hands first priority to index 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            burst_cnt  <= burst_cnt_n;
        end
    end

    // Arbitrate in IDLE; in BURST count writes and end on the last word or a dropped request
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        burst_cnt_n  = burst_cnt;
        in_burst     = state == BURST;
        wr           = in_burst && bus.req[owner] && !bus.fifo_full;
        if (!in_burst) begin
            if (pick_valid) begin
                state_n     = BURST;
                owner_n     = pick;
                burst_cnt_n = '0;
            end
        end else begin
            if (wr)
                burst_cnt_n = burst_cnt + 1'b1;
            if ((wr && burst_cnt == CW'(MAX_BURST - 1)) || !bus.req[owner]) begin
                state_n      = IDLE;
                last_owner_n = owner;
                burst_cnt_n  = '0;
            end
        end
    end

    // Output decode: everything is zero outside a burst
    always_comb begin
        bus.busy        = in_burst;
        bus.grant       = in_burst ? owner_oh : '0;
        bus.fifo_wr     = wr;
        bus.ack         = wr ? owner_oh : '0;
        bus.fifo_w_data = in_burst ? bus.wr_data_in[int'(owner) * DATA_WIDTH +: DATA_WIDTH] : '0;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario-driven scoreboard bench for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int wcnt[4];
    int ecnt[4];
    logic [17:0] exp_q[$];
    logic [17:0] o;
    logic [17:0] e;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Producer i's k-th word
    function automatic logic [7:0] word(input int i, input int k);
        return 8'(i * 64 + k);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++)
            bus.wr_data_in[i*8 +: 8] = word(i, wcnt[i]);
    endtask

    // Expected {grant, ack, fifo_wr, fifo_w_data, busy}; own < 0 means idle
    task automatic push(input int own, input bit w);
        logic [3:0] g;
        logic [7:0] d;
        g = 4'b0;
        d = 8'h00;
        if (own >= 0) begin
            g = 4'(1 << own);
            d = word(own, ecnt[own]);
            if (w) ecnt[own]++;
        end
        exp_q.push_back({g, w ? g : 4'b0, w, d, own >= 0});
    endtask

    // Sample outputs mid-cycle, then advance producers whose word was acked
    task automatic tick(output logic [17:0] obs);
        logic [3:0] a;
        @(negedge clk);
        obs = {bus.grant, bus.ack, bus.fifo_wr, bus.fifo_w_data, bus.busy};
        a = bus.ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (a[i]) wcnt[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        bus.req = 4'b0;
        bus.fifo_full = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_data();
    endtask

    task automatic test_reset();
        bus.req = 4'b1111;
        bus.fifo_full = 1'b0;
        drive_data();
        #2 reset = 1'b1;
        #1;
        o = {bus.grant, bus.ack, bus.fifo_wr, bus.fifo_w_data, bus.busy};
        push(-1, 0);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_async: got %b expected %b", o, e); end
        for (int c = 0; c < 3; c++) begin
            if (c == 1) reset = 1'b0;
            push(c == 2 ? 0 : -1, c == 2);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            push((c == 0 || c == 5) ? -1 : 0, c != 0 && c != 5);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL single c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    task automatic test_two_producers();
        do_reset();
        bus.req = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            push((c % 5 == 0) ? -1 : ((c / 5) % 2 == 0 ? 0 : 2), c % 5 != 0);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL two_prod c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            bus.fifo_full = c >= 3 && c <= 5;
            push((c == 0 || c == 8) ? -1 : 0, c != 0 && c != 8 && !(c >= 3 && c <= 5));
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL full_stall c%0d: got %b expected %b", c, o, e); end
        end
        bus.fifo_full = 1'b0;
    endtask

    task automatic test_req_drop();
        do_reset();
        bus.req = 4'b1010;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) bus.req = 4'b1000;
            if (c == 0 || c == 4) push(-1, 0);
            else if (c <= 3) push(1, c != 3);
            else push(3, 1);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL req_drop c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b1000;
        for (int c = 0; c < 15; c++) begin
            if (c == 5) bus.req = 4'b1001;
            if (c % 5 == 0) push(-1, 0);
            else push(c >= 6 && c <= 9 ? 0 : 3, 1);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            push(c == 0 ? -1 : 1, c != 0);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_pre c%0d: got %b expected %b", c, o, e); end
        end
        reset = 1'b1;
        bus.req = 4'b1001;
        #1;
        o = {bus.grant, bus.ack, bus.fifo_wr, bus.fifo_w_data, bus.busy};
        push(-1, 0);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL mid_reset_async: got %b expected %b", o, e); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0 || c == 5) push(-1, 0);
            else push(c == 6 ? 3 : 0, 1);
            tick(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_post c%0d: got %b expected %b", c, o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wcnt[i] = 0;
            ecnt[i] = 0;
        end
        test_reset();
        test_single();
        test_two_producers();
        test_full_stall();
        test_req_drop();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO controller and drives that controller's `wr` and write-data inputs. It grants one producer at a time for a burst of up to `MAX_BURST` words, respects the FIFO full flag, and returns a per-producer acknowledge for every accepted word.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of producers, ≥ 2.
- `DATA_WIDTH`, default 8: word width; matches the FIFO.
- `MAX_BURST`, default 4: maximum words written per grant, ≥ 1.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  `NUM_REQ`: producer i has a word ready on its data slice.
- `wr_data_in`  in  `NUM_REQ*DATA_WIDTH`: producer i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_full`  in  1: full flag from the FIFO controller.
- `grant`  out  `NUM_REQ`: registered one-hot burst owner; all zero when idle.
- `ack`  out  `NUM_REQ`: one-hot; the owner's word is accepted this cycle.
- `fifo_wr`  out  1: write strobe to the FIFO.
- `fifo_w_data`  out  `DATA_WIDTH`: owner's data slice; all zero when not granted.
- `busy`  out  1: high while in state BURST.

## Operation
- FSM states: IDLE and BURST. Registers:
  - `state`
  - `owner` ($clog2(NUM_REQ) bits)
  - `last_owner` ($clog2(NUM_REQ) bits)
  - `burst_cnt` ($clog2(MAX_BURST+1) bits)
- IDLE, when any `req` bit is set:
  - Search cyclically starting at index `last_owner+1` (mod `NUM_REQ`); the first set `req` bit wins.
  - Register that index as `owner`, clear `burst_cnt`, go to BURST.
- IDLE, when no `req` bit is set: stay in IDLE.
- BURST:
  - `grant` = one-hot(`owner`).
  - `fifo_wr` = `req[owner] & ~fifo_full`, combinational from registered state and inputs.
  - `ack[owner]` = `fifo_wr`; all other `ack` bits are 0.
  - `fifo_w_data` = `owner` slice of `wr_data_in`.
  - Each write increments `burst_cnt`.
- BURST ends (next state IDLE, `last_owner` ← `owner`) on either condition:
  - A write occurs with `burst_cnt == MAX_BURST-1`, or
  - `req[owner]` is 0 at the clock edge.
- `fifo_full` high during BURST: no write and no ack. The owner keeps the grant and `burst_cnt` holds. A full stall never ends a burst.
- Requests from non-owners are ignored until the burst ends. No preemption.
- Producers must hold `req` and data stable until `ack`; a word is consumed only in an `ack` cycle.
- Reset value of every output is 0. State resets to IDLE, `burst_cnt` to 0, `last_owner` to `NUM_REQ-1`, so index 0 has first priority after reset.
- Reset mid-burst: the burst is aborted immediately (asynchronously); no partial-burst state survives.

## Timing
- Request to grant: `req` sampled high at edge N gives `grant`/`busy` high in the cycle after edge N. The first write can occur in that same cycle.
- Full-rate burst: `MAX_BURST` consecutive `fifo_wr` cycles.
- After every burst there is exactly one IDLE cycle (arbitration bubble) with `grant` = 0 before the next grant. Peak throughput is MAX_BURST/(MAX_BURST+1).
- `fifo_wr`/`ack` have zero latency from `fifo_full`. The FIFO controller's full flag is registered-length derived, so no combinational loop exists.

## Structure
- Shared package `fifo_pkg`:
  - `arb_state_t` enum {IDLE, BURST}.
  - Helper function for index-to-one-hot.
- Sub-module `rr_priority_pick`: combinational rotating-priority encoder.
  - Inputs: `req` and the start index.
  - Outputs: `valid` and the winning index.
  - Parameterised by `NUM_REQ`.
- Top module holds the FSM, counters, data mux and output decode.

## Test plan
- Single producer, `req[0]` held, `fifo_full`=0:
  - `grant` = 0001 in cycles 1–4 with `fifo_wr` each cycle (4 writes).
  - `grant` = 0 in cycle 5; regrant in cycle 6.
- `req[0]` and `req[2]` held continuously:
  - Burst order 0, 2, 0, 2, each burst 4 writes, one bubble between bursts.
  - `fifo_w_data` equals each owner's slice.
- `fifo_full` raised for 3 cycles after the owner's 2nd write:
  - `fifo_wr`/`ack` low for those 3 cycles, `grant` held.
  - Remaining 2 writes complete, then IDLE.
- Owner 1 drops `req` after 2 acked words while `req[3]` is high: burst ends, bubble, then `grant` = 1000.
- Reset asserted mid-burst:
  - All outputs 0 immediately.
  - After release with `req` = 1001, index 0 is granted first; index 3 is granted only after index 0's burst ends.
- Wrap-around: last owner 3 with `req` = 1001 → index 0 granted, then index 3.
